// File: rtl/sync_fifo_dw.sv
// sync_fifo_dw: single-clock FIFO with independent, power-of-two-related
// input and output widths. Storage is kept in slots of min(DIN_WIDTH, DOUT_WIDTH)
// bits. A write scatters one input word over R_IN slots. A read gathers R_OUT
// slots into one output word. Flags are registered from the post-edge occupancy.
// Optional build macro: SYNC_FIFO_DW_DATA_COUNT_EN adds the wr_data_count and
// rd_data_count outputs.
module sync_fifo_dw #(
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT_EN    = 1,
  parameter int MSB_FIFO   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow
`ifdef SYNC_FIFO_DW_DATA_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   wr_data_count,
  output logic [ADDR_WIDTH:0]   rd_data_count
`endif
);

  localparam int MIN_W = (DIN_WIDTH < DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH;
  localparam int MAX_W = (DIN_WIDTH < DOUT_WIDTH) ? DOUT_WIDTH : DIN_WIDTH;
  localparam int R_IN  = DIN_WIDTH / MIN_W;
  localparam int R_OUT = DOUT_WIDTH / MIN_W;
  localparam int R_MAX = MAX_W / MIN_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  localparam cnt_t R_IN_C    = cnt_t'(R_IN);
  localparam cnt_t R_OUT_C   = cnt_t'(R_OUT);
  localparam cnt_t FULL_TH   = cnt_t'(DEPTH - R_IN);
  localparam cnt_t AFULL_TH  = cnt_t'(DEPTH - 2 * R_IN);
  localparam cnt_t AEMPTY_TH = cnt_t'(2 * R_OUT);

  // Reject width ratios that are not powers of two and buffers too shallow
  // to hold two of the wider words.
  generate
    if ((MAX_W % MIN_W) != 0 || (R_MAX & (R_MAX - 1)) != 0) begin : g_bad_ratio
      $error("sync_fifo_dw: width ratio must be a power of two");
    end
    if (DEPTH < 2 * R_MAX) begin : g_bad_depth
      $error("sync_fifo_dw: 2**ADDR_WIDTH must be at least 2*max(R_IN, R_OUT)");
    end
  endgenerate

  logic [MIN_W-1:0]      mem [DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  cnt_t                  count;
  cnt_t                  count_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DOUT_WIDTH-1:0] head_word;

  // Accept requests against the pre-edge flags and compute the net occupancy.
  always_comb begin
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    count_next = count + (wr_acc ? R_IN_C : '0) - (rd_acc ? R_OUT_C : '0);
  end

  // Scatter an accepted input word across R_IN consecutive slots.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int unsigned i = 0; i < R_IN; i++) begin
        if (MSB_FIFO != 0)
          mem[wr_ptr + ptr_t'(i)] <= din[(R_IN - 1 - i) * MIN_W +: MIN_W];
        else
          mem[wr_ptr + ptr_t'(i)] <= din[i * MIN_W +: MIN_W];
      end
    end
  end

  // Gather R_OUT slots from the head into one output word.
  always_comb begin
    head_word = '0;
    for (int unsigned j = 0; j < R_OUT; j++) begin
      if (MSB_FIFO != 0)
        head_word[(R_OUT - 1 - j) * MIN_W +: MIN_W] = mem[rd_ptr + ptr_t'(j)];
      else
        head_word[j * MIN_W +: MIN_W] = mem[rd_ptr + ptr_t'(j)];
    end
  end

  // Pointers, occupancy, status flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + ptr_t'(R_IN);
      if (rd_acc)
        rd_ptr <= rd_ptr + ptr_t'(R_OUT);
      count        <= count_next;
      full         <= count_next > FULL_TH;
      almost_full  <= (count_next > AFULL_TH) && !(count_next > FULL_TH);
      empty        <= count_next < R_OUT_C;
      almost_empty <= (count_next >= R_OUT_C) && (count_next < AEMPTY_TH);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      // Fall-through: the head word is always presented.
      always_comb begin
        dout = head_word;
      end
    end else begin : g_std
      // Standard mode: load the head word only on an accepted read.
      always_ff @(posedge clk) begin
        if (rst)
          dout <= '0;
        else if (rd_acc)
          dout <= head_word;
      end
    end
  endgenerate

`ifdef SYNC_FIFO_DW_DATA_COUNT_EN
  // Word counts on each side, tracking the registered occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data_count <= '0;
      rd_data_count <= '0;
    end else begin
      wr_data_count <= count_next / R_IN_C;
      rd_data_count <= count_next / R_OUT_C;
    end
  end
`endif

endmodule
